polyvec_xform_seq: RTL and testbench
====================================

POLYVEC_XFORM_SEQ -- requirements
Module: polyvec_xform_seq

Interface
REQ-001 Parameter K, default 6, number of polynomials per vector (1..8).
REQ-002 Parameter N, default 256, coefficients per polynomial.
REQ-003 Parameter W, default 32, signed coefficient width in bits.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rtr  input  1  request; level held by upstream until rts seen.
REQ-007 mode  input  1  0 = forward NTT, 1 = inverse NTT to Montgomery; sampled with rtr.
REQ-008 mask  input  K  bit i = 1 transforms polynomial i; 0 passes it through unchanged.
REQ-009 linear_v_in  input  K*N*W  signed vector; polynomial i at bits [i*N*W +: N*W].
REQ-010 linear_v_out  output  K*N*W  signed result vector, same packing.
REQ-011 rts  output  1  result ready; held until rtr is low.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 eng_rtr  output  1  request to the external single-polynomial engine.
REQ-014 eng_mode  output  1  latched mode, stable from LOAD to IDLE.
REQ-015 eng_in  output  N*W  polynomial under transform, registered.
REQ-016 eng_out  input  N*W  engine result, valid while eng_rts is high.
REQ-017 eng_rts  input  1  engine done; four-phase handshake with eng_rtr.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SCAN, ISSUE, WAIT, RELEASE, DONE, with Moore outputs.
REQ-019 IDLE: rts=0, eng_rtr=0; rtr=1 -> LOAD.
REQ-020 LOAD (1 cycle): capture linear_v_in into the output bank, latch mode and mask, idx<=0 -> SCAN.
REQ-021 SCAN (1 cycle per index): idx==K -> DONE; mask[idx]=1 -> eng_in<=polynomial idx, go to ISSUE; else idx<=idx+1, stay in SCAN.
REQ-022 ISSUE: eng_rtr=1 -> WAIT.
REQ-023 WAIT: eng_rtr=1; on eng_rts=1, write eng_out to bank[idx], idx<=idx+1 -> RELEASE.
REQ-024 RELEASE: eng_rtr=0; stay until eng_rts=0, then -> SCAN.
REQ-025 DONE: rts=1; rtr=0 -> IDLE; otherwise hold.
REQ-026 Masked-off polynomials SHALL appear in linear_v_out bit-identical to their input.
REQ-027 mask=0: rts SHALL rise K+2 cycles after the edge that first samples rtr=1.
REQ-028 Changes on rtr, mode, mask or linear_v_in after LOAD SHALL be ignored until the next IDLE.
REQ-029 If rtr drops before DONE, the operation SHALL complete, rts SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-030 linear_v_out SHALL hold its value from DONE until the next LOAD.
REQ-031 idx SHALL be clog2(K+1) bits wide and never exceed K; the block performs no coefficient arithmetic.
REQ-032 eng_rts=1 outside WAIT/RELEASE SHALL be ignored.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, rts=0, eng_rtr=0, busy=0, idx=0 and clear the output bank, eng_in, eng_mode, mask and mode to 0.
REQ-034 Reset mid-operation SHALL abandon the operation without producing rts; after release, the block SHALL accept a new rtr normally.

Structure
REQ-035 N, default K/W, the state encoding and the state width SHALL reside in the shared package polyvec_pkg.
REQ-036 The K-entry result register bank with indexed write and load-all SHALL be the sub-module polyvec_result_bank.

Verification
REQ-037 The bench engine model SHALL add 1 to each coefficient if mode=1 and subtract 1 if mode=0, with eng_rts rising 3 cycles after eng_rtr and falling 1 cycle after eng_rtr falls.
REQ-038 K=6, mask=6'b111111, mode=1, all coefficients 5 -> all outputs 6, six eng_rtr pulses, rts high until rtr low.
REQ-039 mask=6'b000000 -> linear_v_out equals input, no eng_rtr pulse, rts 8 cycles after rtr sampled.
REQ-040 mask=6'b100101, mode=0, coefficients 10 -> polynomials 0, 2, 5 become 9 and the others stay 10; eng_mode=0 throughout.
REQ-041 rtr high for 2 cycles only -> operation completes, rts one cycle wide, then IDLE.
REQ-042 reset asserted while in WAIT on polynomial 3 -> rts and eng_rtr go to 0 immediately and the output bank goes to 0; a following full request completes correctly.

Source files
------------

// File: rtl/polyvec_pkg.sv
// polyvec_pkg: shared sizing defaults and FSM state encoding for the
// polynomial-vector transform sequencer.
//   N_DEF    coefficients per polynomial
//   K_DEF    polynomials per vector
//   W_DEF    signed coefficient width in bits
//   STATE_W  width of the sequencer state register
//   state_t  sequencer states
package polyvec_pkg;
  localparam int N_DEF = 256;
  localparam int K_DEF = 6;
  localparam int W_DEF = 32;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_DONE
  } state_t;
endpackage

// File: rtl/polyvec_result_bank.sv
// polyvec_result_bank: K-entry polynomial register bank with load-all and
// single-entry indexed write, plus a combinational read of entry idx.
//   clock, reset  rising-edge clock, asynchronous active-high clear
//   load          copy load_data into every entry (wins over we)
//   load_data     packed vector, entry i at [i*N*W +: N*W]
//   we            write wdata into entry idx
//   idx           entry index for write and read (values >= K select nothing)
//   wdata         polynomial to write
//   data          whole bank, same packing as load_data
//   rd_data       entry idx, zero when idx >= K
module polyvec_result_bank
  import polyvec_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int IW = $clog2(K + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [K*N*W-1:0] load_data,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [N*W-1:0]   wdata,
  output logic [K*N*W-1:0] data,
  output logic [N*W-1:0]   rd_data
);
  always_ff @(posedge clock or posedge reset)
    if (reset) data <= '0;
    else if (load) data <= load_data;
    else if (we)
      for (int i = 0; i < K; i++)
        if (idx == IW'(i)) data[i*N*W +: N*W] <= wdata;
  // Decoded mux keeps every select in range even though idx can reach K.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < K; i++)
      if (idx == IW'(i)) rd_data = data[i*N*W +: N*W];
  end
endmodule

// File: rtl/polyvec_xform_seq.sv
// polyvec_xform_seq: walks a K-polynomial vector and hands each masked
// polynomial to an external single-polynomial NTT engine, collecting results.
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   rtr, rts       upstream four-phase request / result-ready
//   mode           0 forward NTT, 1 inverse to Montgomery (latched at LOAD)
//   mask           bit i selects polynomial i for transform (latched at LOAD)
//   linear_v_in    input vector, polynomial i at [i*N*W +: N*W]
//   linear_v_out   result vector, same packing, stable from DONE to next LOAD
//   busy           high outside IDLE
//   eng_rtr, eng_rts  four-phase handshake with the engine
//   eng_mode       latched mode
//   eng_in         registered polynomial under transform
//   eng_out        engine result, valid while eng_rts is high
module polyvec_xform_seq
  import polyvec_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rtr,
  input  logic             mode,
  input  logic [K-1:0]     mask,
  input  logic [K*N*W-1:0] linear_v_in,
  output logic [K*N*W-1:0] linear_v_out,
  output logic             rts,
  output logic             busy,
  output logic             eng_rtr,
  output logic             eng_mode,
  output logic [N*W-1:0]   eng_in,
  input  logic [N*W-1:0]   eng_out,
  input  logic             eng_rts
);
  localparam int IW = $clog2(K + 1);
  state_t state, next;
  logic [IW-1:0] idx;
  logic [K-1:0] mask_q;
  logic [K:0] mask_ext;
  logic at_end;
  logic [N*W-1:0] rd_data;
  // Extra zero bit lets mask_ext be indexed by any idx value up to K.
  assign mask_ext = {1'b0, mask_q};
  assign at_end = idx == IW'(K);
  polyvec_result_bank #(.K(K), .N(N), .W(W), .IW(IW)) u_bank (
    .clock(clock),
    .reset(reset),
    .load(state == S_LOAD),
    .load_data(linear_v_in),
    .we(state == S_WAIT && eng_rts),
    .idx(idx),
    .wdata(eng_out),
    .data(linear_v_out),
    .rd_data(rd_data)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    rts = state == S_DONE;
    busy = state != S_IDLE;
    eng_rtr = state == S_ISSUE || state == S_WAIT;
    case (state)
      S_IDLE:    next = rtr ? S_LOAD : S_IDLE;
      S_LOAD:    next = S_SCAN;
      S_SCAN:    next = at_end ? S_DONE : mask_ext[idx] ? S_ISSUE : S_SCAN;
      S_ISSUE:   next = S_WAIT;
      S_WAIT:    next = eng_rts ? S_RELEASE : S_WAIT;
      S_RELEASE: next = eng_rts ? S_RELEASE : S_SCAN;
      S_DONE:    next = rtr ? S_DONE : S_IDLE;
      default:   next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx <= '0;
      mask_q <= '0;
      eng_mode <= 1'b0;
      eng_in <= '0;
    end else if (state == S_LOAD) begin
      idx <= '0;
      mask_q <= mask;
      eng_mode <= mode;
    end else if (state == S_SCAN && !at_end) begin
      if (mask_ext[idx]) eng_in <= rd_data;
      else idx <= idx + IW'(1);
    end else if (state == S_WAIT && eng_rts) begin
      idx <= idx + IW'(1);
    end
endmodule

// File: tb/tb_polyvec_xform_seq.sv
// tb_polyvec_xform_seq: randomized self-checking bench with an engine model
// and a per-coefficient reference of the expected result vector.
module tb_polyvec_xform_seq;
  localparam int K = 6;
  localparam int N = 256;
  localparam int W = 32;
  logic clock = 0;
  logic reset, rtr, mode, rts, busy, eng_rtr, eng_mode, eng_rts;
  logic [K-1:0] mask;
  logic [K*N*W-1:0] vin, vout;
  logic [N*W-1:0] eng_in, eng_out;
  int checks = 0, errors = 0;
  int pulses = 0, bad_mode = 0, cnt = 0;
  bit prev = 0, cur_mode = 0;

  always #5 clock = ~clock;

  polyvec_xform_seq #(.K(K), .N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .rtr(rtr), .mode(mode), .mask(mask),
    .linear_v_in(vin), .linear_v_out(vout), .rts(rts), .busy(busy),
    .eng_rtr(eng_rtr), .eng_mode(eng_mode), .eng_in(eng_in),
    .eng_out(eng_out), .eng_rts(eng_rts)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] xform_poly(input logic [N*W-1:0] p, input bit md);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = md ? p[j*W +: W] + W'(1) : p[j*W +: W] - W'(1);
    return r;
  endfunction

  // Engine: answers 3 cycles after eng_rtr rises, drops eng_rts 1 cycle after eng_rtr falls.
  initial begin
    eng_rts = 0;
    eng_out = '0;
    forever begin
      @(negedge clock);
      if (eng_rtr && !prev) pulses++;
      prev = eng_rtr;
      if (eng_rtr && eng_mode !== cur_mode) bad_mode++;
      if (eng_rtr) begin
        cnt++;
        if (cnt == 3) begin
          eng_out = xform_poly(eng_in, cur_mode);
          eng_rts = 1;
        end
      end else begin
        cnt = 0;
        eng_rts = 0;
      end
    end
  end

  task automatic fill_const(input int c);
    for (int i = 0; i < K*N; i++) vin[i*W +: W] = W'(c);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < K*N; i++) vin[i*W +: W] = W'($urandom);
  endtask

  task automatic check_vec(input string tag, input logic [K*N*W-1:0] sent, input bit md, input logic [K-1:0] mk);
    logic [N*W-1:0] e, g;
    int j;
    for (int i = 0; i < K; i++) begin
      e = mk[i] ? xform_poly(sent[i*N*W +: N*W], md) : sent[i*N*W +: N*W];
      g = vout[i*N*W +: N*W];
      j = 0;
      while (j < N - 1 && g[j*W +: W] === e[j*W +: W]) j++;
      check($sformatf("%s_poly%0d_c%0d", tag, i, j), 64'(g[j*W +: W]), 64'(e[j*W +: W]));
    end
  endtask

  task automatic run_op(input string tag, input bit md, input logic [K-1:0] mk, input bit short_req);
    logic [K*N*W-1:0] sent;
    int n, p0;
    sent = vin;
    cur_mode = md;
    bad_mode = 0;
    p0 = pulses;
    @(negedge clock);
    rtr = 1;
    mode = md;
    mask = mk;
    @(posedge clock);
    #1;
    n = 0;
    while (!rts && n < 400) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1) begin
        mode = ~md;
        mask = ~mk;
        vin = ~vin;
        if (short_req) rtr = 0;
      end
    end
    check({tag, "_rts_seen"}, 64'(rts), 64'(1));
    if (mk == 0) check({tag, "_latency"}, 64'(n), 64'(K + 2));
    if (short_req) begin
      @(posedge clock);
      #1;
      check({tag, "_rts_one_cycle"}, 64'(rts), 64'(0));
    end else begin
      repeat (2) begin
        @(posedge clock);
        #1;
        check({tag, "_rts_held"}, 64'(rts), 64'(1));
      end
      rtr = 0;
      @(posedge clock);
      #1;
      check({tag, "_rts_drop"}, 64'(rts), 64'(0));
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check({tag, "_pulses"}, 64'(pulses - p0), 64'($countones(mk)));
    check({tag, "_eng_mode"}, 64'(bad_mode), 64'(0));
    check_vec(tag, sent, md, mk);
  endtask

  initial begin
    int n, p0;
    reset = 1;
    rtr = 0;
    mode = 0;
    mask = '0;
    vin = '0;
    repeat (3) @(negedge clock);
    check("rst_rts", 64'(rts), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_eng_rtr", 64'(eng_rtr), 64'(0));
    check("rst_bank", 64'(|vout), 64'(0));
    check("rst_eng_in", 64'(|eng_in), 64'(0));
    check("rst_eng_mode", 64'(eng_mode), 64'(0));
    reset = 0;
    fill_const(5);
    run_op("all_inv", 1, 6'b111111, 0);
    fill_rand();
    run_op("mask0", 1'($urandom), 6'b000000, 0);
    fill_const(10);
    run_op("fwd_100101", 0, 6'b100101, 0);
    fill_rand();
    run_op("short_rtr", 1, K'($urandom), 1);
    fill_rand();
    cur_mode = 1;
    p0 = pulses;
    @(negedge clock);
    rtr = 1;
    mode = 1;
    mask = '1;
    n = 0;
    while (pulses < p0 + 4 && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("rst_mid_reach_p3", 64'(pulses - p0), 64'(4));
    @(posedge clock);
    #1;
    reset = 1;
    #1;
    check("rst_mid_rts", 64'(rts), 64'(0));
    check("rst_mid_eng_rtr", 64'(eng_rtr), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_bank", 64'(|vout), 64'(0));
    rtr = 0;
    @(negedge clock);
    reset = 0;
    fill_rand();
    run_op("after_rst", 1, 6'b111111, 0);
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run_op($sformatf("rand%0d", t), 1'($urandom), K'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
